memory_responder: RTL and testbench

Responder end of the CPU memory bus: accepts strobe/address/writeEnable/data requests issued by `RiscvCore` and completes them with `ready`, backed by an on-chip word RAM. Sits between the core's `IMemoryBus` (flattened at the top level, where the tri-state data line is resolved) and block RAM. It occupies a configurable window of the address space; the default window starts at the core reset PC (16'h2000).

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/memory_responder_ram.sv | 25 ++
 rtl/memory_responder.sv | 142 ++++++++++++++
 tb/tb_memory_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: responder FSM states, data width and the
// default window base that coincides with the core reset PC.
package mem_bus_pkg;

    localparam int MEM_DATA_SIZE = 32;

    // The core fetches its first instruction here, so the RAM window starts here too.
    localparam int unsigned DEFAULT_BASE_ADDRESS = 32'h0000_2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } mem_resp_state_t;

    function automatic int indexBits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous word RAM with a registered read port; written so it
// maps onto block RAM (read-first, no reset on the array or the read register).
module memory_responder_ram
    import mem_bus_pkg::*;
#(
    parameter int WORDS = 2048,
    parameter int WIDTH = MEM_DATA_SIZE
) (
    input  logic                          clock,
    input  logic                          writeEnable,
    input  logic [indexBits(WORDS)-1:0]   address,
    input  logic [WIDTH-1:0]              writeData,
    output logic [WIDTH-1:0]              readData
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (writeEnable) begin
            mem[address] <= writeData;
        end
        readData <= mem[address];
    end

endmodule

// File: rtl/memory_responder.sv
// Responder for the core memory bus: four-phase strobe/ready handshake in front
// of an on-chip word RAM. Define MEM_RESPONDER_BOUNDS_EN to range-check the window.
module memory_responder
    import mem_bus_pkg::*;
#(
    parameter int          ADDRESS_SIZE = 15,
    parameter int unsigned BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter int          MEM_WORDS    = 2048,
    parameter int          WAIT_STATES  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_SIZE-1:0]  memAddress,
    input  logic                     memStrobe,
    input  logic                     memWriteEnable,
    input  logic [MEM_DATA_SIZE-1:0] memDataIn,
    output logic [MEM_DATA_SIZE-1:0] memDataOut,
    output logic                     memDataOe,
    output logic                     memReady,
    output logic                     memError
);

    localparam int IDX_W = indexBits(MEM_WORDS);

    mem_resp_state_t          state;
    logic [3:0]               waitCount;
    logic                     latWrite;
    logic [MEM_DATA_SIZE-1:0] latData;
    logic [IDX_W-1:0]         latIndex;

    logic [IDX_W-1:0]         curIndex;
    logic [IDX_W-1:0]         ramAddress;
    logic                     ramWe;
    logic [MEM_DATA_SIZE-1:0] ramReadData;
    logic                     commit;
    logic                     writeAllowed;
    logic [MEM_DATA_SIZE-1:0] readResult;

    // Offset wraps in ADDRESS_SIZE bits; only the word-index bits survive.
    assign curIndex = IDX_W'((memAddress - ADDRESS_SIZE'(BASE_ADDRESS)) >> 2);

    // In IDLE the RAM reads the live address so data is ready by the time WAIT ends.
    assign ramAddress = (state == IDLE) ? curIndex : latIndex;

    assign commit = (state == WAIT) && memStrobe && (waitCount == 4'd0);
    assign ramWe  = commit && latWrite && writeAllowed;

`ifdef MEM_RESPONDER_BOUNDS_EN
    logic [31:0] addrWide;
    logic        curInRange;
    logic        latInRange;

    assign addrWide   = 32'(memAddress);
    assign curInRange = (addrWide >= BASE_ADDRESS) &&
                        (addrWide < (BASE_ADDRESS + 32'(4 * MEM_WORDS)));

    assign writeAllowed = latInRange;
    assign readResult   = latInRange ? ramReadData : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            latInRange <= 1'b0;
            memError   <= 1'b0;
        end else begin
            if (state == IDLE && memStrobe) begin
                latInRange <= curInRange;
            end
            if (commit) begin
                memError <= !latInRange;
            end else if (state != READY || !memStrobe) begin
                memError <= 1'b0;
            end
        end
    end
`else
    assign writeAllowed = 1'b1;
    assign readResult   = ramReadData;
    assign memError     = 1'b0;
`endif

    memory_responder_ram #(
        .WORDS (MEM_WORDS),
        .WIDTH (MEM_DATA_SIZE)
    ) ram (
        .clock       (clock),
        .writeEnable (ramWe),
        .address     (ramAddress),
        .writeData   (latData),
        .readData    (ramReadData)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            waitCount  <= 4'd0;
            latWrite   <= 1'b0;
            latData    <= '0;
            latIndex   <= '0;
            memReady   <= 1'b0;
            memDataOe  <= 1'b0;
            memDataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memStrobe) begin
                        latWrite  <= memWriteEnable;
                        latData   <= memDataIn;
                        latIndex  <= curIndex;
                        waitCount <= 4'(WAIT_STATES);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!memStrobe) begin
                        // Initiator gave up: drop the request without touching RAM.
                        state <= IDLE;
                    end else if (waitCount == 4'd0) begin
                        memReady   <= 1'b1;
                        memDataOe  <= !latWrite;
                        memDataOut <= latWrite ? '0 : readResult;
                        state      <= READY;
                    end else begin
                        waitCount <= waitCount - 4'd1;
                    end
                end
                READY: begin
                    if (!memStrobe) begin
                        memReady  <= 1'b0;
                        memDataOe <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    memReady  <= 1'b0;
                    memDataOe <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: table of single transfers plus
// hand-written abort, held-strobe and reset sequences.
module tb_memory_responder;

    localparam int WS = 1;

    logic        clock;
    logic        reset;
    logic [14:0] memAddress;
    logic        memStrobe;
    logic        memWriteEnable;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic        memDataOe;
    logic        memReady;
    logic        memError;

    int nChecks = 0;
    int nFails  = 0;

    memory_responder #(
        .ADDRESS_SIZE (15),
        .BASE_ADDRESS (32'h2000),
        .MEM_WORDS    (2048),
        .WAIT_STATES  (WS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .memAddress     (memAddress),
        .memStrobe      (memStrobe),
        .memWriteEnable (memWriteEnable),
        .memDataIn      (memDataIn),
        .memDataOut     (memDataOut),
        .memDataOe      (memDataOe),
        .memReady       (memReady),
        .memError       (memError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [31:0] data;
        logic [31:0] expData;
        logic        expOe;
        logic        expErr;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    function automatic void check(input string name, input logic [31:0] actual,
                                  input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endfunction

    // Drives one request, returns observations when memReady rises (or the
    // cycle budget runs out), holds strobe for holdCycles, then releases it.
    task automatic runTransfer(input logic we, input logic [14:0] addr,
                               input logic [31:0] data, input int holdCycles,
                               output logic [31:0] rdata, output logic oe,
                               output logic err, output int latency);
        @(negedge clock);
        memStrobe      = 1'b1;
        memWriteEnable = we;
        memAddress     = addr;
        memDataIn      = data;
        @(posedge clock);
        latency = 0;
        @(negedge clock);
        while (!memReady && latency < 20) begin
            @(negedge clock);
            latency++;
        end
        rdata = memDataOut;
        oe    = memDataOe;
        err   = memError;
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clock);
            check("held_ready", 32'(memReady), 32'd1);
        end
        memStrobe = 1'b0;
        @(negedge clock);
        check("ready_drop", 32'(memReady), 32'd0);
        check("oe_drop", 32'(memDataOe), 32'd0);
    endtask

    task automatic doRead(input string name, input logic [14:0] addr,
                          input logic [31:0] expData);
        logic [31:0] rd;
        logic        oe;
        logic        err;
        int          lat;
        runTransfer(1'b0, addr, 32'h0, 0, rd, oe, err, lat);
        check({name, "_lat"}, 32'(lat), 32'(1 + WS));
        check({name, "_data"}, rd, expData);
        check({name, "_oe"}, 32'(oe), 32'd1);
    endtask

    task automatic doWrite(input string name, input logic [14:0] addr,
                           input logic [31:0] data, input int hold);
        logic [31:0] rd;
        logic        oe;
        logic        err;
        int          lat;
        runTransfer(1'b1, addr, data, hold, rd, oe, err, lat);
        check({name, "_lat"}, 32'(lat), 32'(1 + WS));
        check({name, "_oe"}, 32'(oe), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        oe;
        logic        err;
        int          lat;

        vecs[0]  = '{1'b1, 15'h2004, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 15'h2004, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 15'h2008, 32'h12345678, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 15'h200B, 32'h0,        32'h12345678, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 15'h2010, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b1, 15'h3FFC, 32'h0BADF00D, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{1'b1, 15'h2000, 32'h00000001, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 15'h3FFD, 32'h0,        32'h0BADF00D, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 15'h2000, 32'h0,        32'h00000001, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 15'h2100, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b0, 15'h2011, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
`ifdef MEM_RESPONDER_BOUNDS_EN
        vecs[11] = '{1'b0, 15'h0100, 32'h0,        32'h00000000, 1'b1, 1'b1};
`else
        // 'h0100 wraps onto the same word index as 'h2100.
        vecs[11] = '{1'b0, 15'h0100, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
`endif

        reset          = 1'b0;
        memStrobe      = 1'b0;
        memWriteEnable = 1'b0;
        memAddress     = '0;
        memDataIn      = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(memReady), 32'd0);
        check("rst_oe", 32'(memDataOe), 32'd0);
        check("rst_err", 32'(memError), 32'd0);
        check("rst_dout", memDataOut, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            runTransfer(vecs[i].we, vecs[i].addr, vecs[i].data, 0, rd, oe, err, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(1 + WS));
            check($sformatf("vec%0d_oe", i), 32'(oe), 32'(vecs[i].expOe));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].expErr));
            if (!vecs[i].we) begin
                check($sformatf("vec%0d_data", i), rd, vecs[i].expData);
            end
            check($sformatf("vec%0d_err_clear", i), 32'(memError), 32'd0);
        end

        // Abort: strobe drops while the responder is still in WAIT.
        @(negedge clock);
        memStrobe      = 1'b1;
        memWriteEnable = 1'b1;
        memAddress     = 15'h2010;
        memDataIn      = 32'hFFFFFFFF;
        @(posedge clock);
        @(negedge clock);
        memStrobe = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("abort_no_ready", 32'(memReady), 32'd0);
        end
        doRead("abort_readback", 15'h2010, 32'hA5A5A5A5);

        // Held strobe: memReady stays up for the whole hold, then drops.
        doWrite("held_write", 15'h2020, 32'h77777777, 5);
        doRead("held_readback", 15'h2020, 32'h77777777);

        // Reset in WAIT: pending write must be dropped.
        @(negedge clock);
        memStrobe      = 1'b1;
        memWriteEnable = 1'b1;
        memAddress     = 15'h2004;
        memDataIn      = 32'h55555555;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rstwait_ready", 32'(memReady), 32'd0);
        check("rstwait_oe", 32'(memDataOe), 32'd0);
        reset     = 1'b1;
        memStrobe = 1'b0;
        @(negedge clock);
        doRead("rstwait_readback", 15'h2004, 32'hDEADBEEF);

        // Reset while a read is being presented: outputs clear immediately.
        @(negedge clock);
        memStrobe      = 1'b1;
        memWriteEnable = 1'b0;
        memAddress     = 15'h2008;
        lat = 0;
        while (!memReady && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("rstready_pre_data", memDataOut, 32'h12345678);
        reset = 1'b0;
        @(negedge clock);
        check("rstready_ready", 32'(memReady), 32'd0);
        check("rstready_oe", 32'(memDataOe), 32'd0);
        check("rstready_dout", memDataOut, 32'h0);
        reset     = 1'b1;
        memStrobe = 1'b0;
        @(negedge clock);
        doRead("rstready_readback", 15'h3FFC, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
